// File: rtl/k2red_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k2red_pkg
//  Description : Shared widths and latency helpers for the K2-RED multiplier
//                stage and the lazy reducer it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package k2red_pkg;

    localparam int DEFAULT_LOG_Q = 32;
    localparam int DEFAULT_LOG_L = 4;

    // Pipeline depth of the downstream K2-RED reducer.
    localparam int K2RED_RED_LAT = 3;

    // Multiplier latency: S1, S2, optional S3, final sum register.
    function automatic int mul_lat(input int speed_opt);
        return 3 + speed_opt;
    endfunction

    // End-to-end delay from operand entry to reduced result.
    function automatic int total_lat(input int speed_opt);
        return mul_lat(speed_opt) + K2RED_RED_LAT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/k2red_mul_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : k2red_mul_stage_if
//  Description : Operand/sideband bundle into the multiplier and the aligned
//                product/sideband bundle out of it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface k2red_mul_stage_if
    import k2red_pkg::*;
#(
    parameter int LOG_Q = DEFAULT_LOG_Q,
    parameter int LOG_L = DEFAULT_LOG_L
);
    logic                 valid_in;
    logic [LOG_Q-1:0]     A_in;
    logic [LOG_Q-1:0]     B_in;
    logic [LOG_Q-1:0]     Q;
    logic [LOG_L-1:0]     l1;
    logic [LOG_L-1:0]     l2;
    logic [LOG_L-1:0]     l3;

    logic                 valid_out;
    logic [2*LOG_Q-1:0]   P;
    logic [LOG_Q-1:0]     Q_out;
    logic [LOG_L-1:0]     l1_out;
    logic [LOG_L-1:0]     l2_out;
    logic [LOG_L-1:0]     l3_out;
    logic                 range_err;

    modport master (
        output valid_in, A_in, B_in, Q, l1, l2, l3,
        input  valid_out, P, Q_out, l1_out, l2_out, l3_out, range_err
    );

    modport slave (
        input  valid_in, A_in, B_in, Q, l1, l2, l3,
        output valid_out, P, Q_out, l1_out, l2_out, l3_out, range_err
    );
endinterface
`default_nettype wire

// File: rtl/k2red_sideband_dly.sv
`default_nettype none
// ============================================================================
//  Module      : k2red_sideband_dly
//  Description : Fixed-depth shift register with synchronous clear, used to
//                keep valid and sideband fields in lockstep with the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module k2red_sideband_dly #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Shift one slot per cycle; reset empties every slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/k2red_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : k2red_mul_stage
//  Description : Pipelined LOG_Q x LOG_Q unsigned multiplier built from four
//                half-width partial products, carrying Q/l1/l2/l3 and a
//                not-reduced-mod-Q flag aligned with the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module k2red_mul_stage
    import k2red_pkg::*;
#(
    parameter int LOG_Q     = DEFAULT_LOG_Q,
    parameter int LOG_L     = DEFAULT_LOG_L,
    parameter int SPEED_OPT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    k2red_mul_stage_if.slave bus
);
    localparam int c_half = LOG_Q / 2;
    localparam int c_pw   = 2 * LOG_Q;
    localparam int c_lat  = mul_lat(SPEED_OPT);
    localparam int c_sbw  = 1 + LOG_Q + 3 * LOG_L;

    // S1 registers
    logic [LOG_Q-1:0] r_a, r_b, r_q;
    logic [LOG_L-1:0] r_l1, r_l2, r_l3;
    logic             r_v;
    logic             w_range_err;

    // S2 partial products
    logic [2*c_half-1:0] r_ll, r_lh, r_hl, r_hh;

    // Final-sum operands (registered in S3 or taken straight from S2)
    logic [2*c_half:0] w_mid;
    logic [c_pw-1:0]   w_outer;
    logic [c_pw-1:0]   r_p;

    logic [c_sbw-1:0]  w_sb_out;

    // S1: capture operands and sideband; clear on reset so nothing stale leaks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_q  <= '0;
            r_l1 <= '0;
            r_l2 <= '0;
            r_l3 <= '0;
            r_v  <= 1'b0;
        end else begin
            r_a  <= bus.A_in;
            r_b  <= bus.B_in;
            r_q  <= bus.Q;
            r_l1 <= bus.l1;
            r_l2 <= bus.l2;
            r_l3 <= bus.l3;
            r_v  <= bus.valid_in;
        end
    end

    assign w_range_err = (r_a >= r_q) | (r_b >= r_q);

    // S2: four half-width products, each small enough for a single DSP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ll <= '0;
            r_lh <= '0;
            r_hl <= '0;
            r_hh <= '0;
        end else begin
            r_ll <= r_a[c_half-1:0]     * r_b[c_half-1:0];
            r_lh <= r_a[c_half-1:0]     * r_b[LOG_Q-1:c_half];
            r_hl <= r_a[LOG_Q-1:c_half] * r_b[c_half-1:0];
            r_hh <= r_a[LOG_Q-1:c_half] * r_b[LOG_Q-1:c_half];
        end
    end

    generate
        if (SPEED_OPT != 0) begin : g_s3
            logic [2*c_half:0] r_mid;
            logic [c_pw-1:0]   r_outer;

            // S3: pre-add the cross terms (carry kept) and butt-join the outer terms.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mid   <= '0;
                    r_outer <= '0;
                end else begin
                    r_mid   <= {1'b0, r_lh} + {1'b0, r_hl};
                    r_outer <= {r_hh, r_ll};
                end
            end

            assign w_mid   = r_mid;
            assign w_outer = r_outer;
        end else begin : g_no_s3
            assign w_mid   = {1'b0, r_lh} + {1'b0, r_hl};
            assign w_outer = {r_hh, r_ll};
        end
    endgenerate

    // Final sum: the true product fits in c_pw bits, so truncation loses nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
        end else begin
            r_p <= w_outer + (c_pw'(w_mid) << c_half);
        end
    end

    // Valid travels S1 -> output; its own clearable delay line.
    k2red_sideband_dly #(
        .WIDTH (1),
        .DEPTH (c_lat - 1)
    ) u_valid_dly (
        .clk (clk),
        .rst (rst),
        .i_d (r_v),
        .o_q (bus.valid_out)
    );

    // Sideband joins at S1 so range_err is taken from the registered operands.
    k2red_sideband_dly #(
        .WIDTH (c_sbw),
        .DEPTH (c_lat - 1)
    ) u_sb_dly (
        .clk (clk),
        .rst (rst),
        .i_d ({w_range_err, r_q, r_l1, r_l2, r_l3}),
        .o_q (w_sb_out)
    );

    assign {bus.range_err, bus.Q_out, bus.l1_out, bus.l2_out, bus.l3_out} = w_sb_out;
    assign bus.P = r_p;

endmodule
`default_nettype wire

// File: tb/tb_k2red_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k2red_mul_stage
//  Description : Directed and random checks of k2red_mul_stage, with the
//                SPEED_OPT=1 and SPEED_OPT=0 builds driven in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k2red_mul_stage;

    localparam int LQ = 32;
    localparam int LL = 4;

    typedef struct packed {
        logic [63:0] p;
        logic [31:0] q;
        logic [3:0]  l1;
        logic [3:0]  l2;
        logic [3:0]  l3;
        logic        re;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k2red_mul_stage_if #(.LOG_Q(LQ), .LOG_L(LL)) bus1 ();
    k2red_mul_stage_if #(.LOG_Q(LQ), .LOG_L(LL)) bus0 ();

    k2red_mul_stage #(.LOG_Q(LQ), .LOG_L(LL), .SPEED_OPT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    k2red_mul_stage #(.LOG_Q(LQ), .LOG_L(LL), .SPEED_OPT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb [2][$];
    bit   [7:0]  vh [2];
    logic [63:0] last_p [2];
    logic        last_re [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input int lat, input logic vo, input logic [63:0] p,
                             input logic [31:0] qo, input logic [3:0] o1, input logic [3:0] o2,
                             input logic [3:0] o3, input logic re, input bit zchk);
        exp_t e;
        chk($sformatf("valid_out_d%0d", d), {63'b0, vo}, {63'b0, vh[d][lat-1]});
        if (zchk) chk($sformatf("p_zero_d%0d", d), p, 64'd0);
        if (vo === 1'b1) begin
            checks++;
            assert (sb[d].size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow_d%0d observed=valid expected=no_output", d);
            end
            if (sb[d].size() != 0) begin
                e = sb[d].pop_front();
                chk($sformatf("P_d%0d", d), p, e.p);
                chk($sformatf("Q_out_d%0d", d), {32'b0, qo}, {32'b0, e.q});
                chk($sformatf("l_out_d%0d", d), {52'b0, o1, o2, o3}, {52'b0, e.l1, e.l2, e.l3});
                chk($sformatf("range_err_d%0d", d), {63'b0, re}, {63'b0, e.re});
            end
            last_p[d]  = p;
            last_re[d] = re;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [3:0] l1, input logic [3:0] l2,
                         input logic [3:0] l3, input bit zchk);
        exp_t e;
        rst = r;
        bus1.valid_in = v; bus1.A_in = a; bus1.B_in = b; bus1.Q = q;
        bus1.l1 = l1; bus1.l2 = l2; bus1.l3 = l3;
        bus0.valid_in = v; bus0.A_in = a; bus0.B_in = b; bus0.Q = q;
        bus0.l1 = l1; bus0.l2 = l2; bus0.l3 = l3;
        e.p  = {32'b0, a} * {32'b0, b};
        e.q  = q;
        e.l1 = l1; e.l2 = l2; e.l3 = l3;
        e.re = (a >= q) || (b >= q);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                vh[d] = '0;
                sb[d].delete();
            end else begin
                vh[d] = {vh[d][6:0], v};
                if (v) sb[d].push_back(e);
            end
        end
        @(negedge clk);
        check_dut(0, 4, bus1.valid_out, bus1.P, bus1.Q_out, bus1.l1_out, bus1.l2_out,
                  bus1.l3_out, bus1.range_err, zchk);
        check_dut(1, 3, bus0.valid_out, bus0.P, bus0.Q_out, bus0.l1_out, bus0.l2_out,
                  bus0.l3_out, bus0.range_err, zchk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb, rq;
        vh[0] = '0; vh[1] = '0;
        last_p[0] = '0; last_p[1] = '0;
        last_re[0] = 1'b0; last_re[1] = 1'b0;

        // Reset held 3 cycles with valid_in high, then 4 quiet cycles.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 4'd1, 4'd2, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1);

        // Single small pair.
        cycle(1'b0, 1'b1, 32'd3, 32'd5, 32'd7, 4'd2, 4'd5, 4'd9, 1'b0);
        idle(5);
        chk("t2_P_d0", last_p[0], 64'd15);
        chk("t2_P_d1", last_p[1], 64'd15);
        chk("t2_re_d0", {63'b0, last_re[0]}, 64'd0);

        // Carry across the half boundary.
        cycle(1'b0, 1'b1, 32'h0001_FFFF, 32'h0001_FFFF, 32'h0003_0001, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(5);
        chk("t3_P_d0", last_p[0], 64'h0000_0003_FFFC_0001);
        chk("t3_P_d1", last_p[1], 64'h0000_0003_FFFC_0001);
        chk("t3_re_d1", {63'b0, last_re[1]}, 64'd0);

        // Maximum operands.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 4'hF, 4'hF, 1'b0);
        idle(5);
        chk("t4_P_d0", last_p[0], 64'hFFFF_FFFE_0000_0001);
        chk("t4_P_d1", last_p[1], 64'hFFFF_FFFE_0000_0001);
        chk("t4_re_d0", {63'b0, last_re[0]}, 64'd1);
        chk("t4_re_d1", {63'b0, last_re[1]}, 64'd1);

        // Random stream with bubbles.
        for (int i = 0; i < 1000; i++) begin
            rq = $urandom;
            ra = ($urandom_range(0, 3) == 0 || rq == 0) ? $urandom : ($urandom % rq);
            rb = ($urandom_range(0, 3) == 0 || rq == 0) ? $urandom : ($urandom % rq);
            cycle(1'b0, ($urandom_range(0, 3) != 0), ra, rb, rq,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'b0);
        end
        idle(6);

        // Reset with three pairs in flight, then one pair right after release.
        cycle(1'b0, 1'b1, 32'd11, 32'd12, 32'd50, 4'd1, 4'd1, 4'd1, 1'b0);
        cycle(1'b0, 1'b1, 32'd13, 32'd14, 32'd50, 4'd2, 4'd2, 4'd2, 1'b0);
        cycle(1'b0, 1'b1, 32'd15, 32'd16, 32'd50, 4'd3, 4'd3, 4'd3, 1'b0);
        cycle(1'b1, 1'b1, 32'd17, 32'd18, 32'd50, 4'd4, 4'd4, 4'd4, 1'b0);
        cycle(1'b0, 1'b1, 32'd100, 32'd200, 32'd1000, 4'd6, 4'd7, 4'd8, 1'b0);
        idle(6);
        chk("t6_P_d0", last_p[0], 64'd20000);
        chk("t6_P_d1", last_p[1], 64'd20000);

        chk("sb_drained_d0", 64'(sb[0].size()), 64'd0);
        chk("sb_drained_d1", 64'(sb[1].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
